// File: rtl/tank_decoder_seq_if.sv
// Bus bundle for the tank decoder: minor-cycle strobe, dual-rail address,
// direction requests, error clear, and the registered select/status outputs.
interface tank_decoder_seq_if #(
  parameter int ADDR_BITS = 2
);
  localparam int TANKS = 2 ** ADDR_BITS;

  logic                 minor_strobe;
  logic [ADDR_BITS-1:0] f_pos;
  logic [ADDR_BITS-1:0] f_neg;
  logic                 t_in;
  logic                 t_out;
  logic                 err_clr;
  logic [TANKS-1:0]     t_sel_in;
  logic [TANKS-1:0]     t_sel_out;
  logic                 busy;
  logic                 rail_err;
  logic                 dir_err;

  modport master (
    output minor_strobe, f_pos, f_neg, t_in, t_out, err_clr,
    input  t_sel_in, t_sel_out, busy, rail_err, dir_err
  );

  modport slave (
    input  minor_strobe, f_pos, f_neg, t_in, t_out, err_clr,
    output t_sel_in, t_sel_out, busy, rail_err, dir_err
  );
endinterface

// File: rtl/tank_decoder_seq.sv
// Dual-rail tank address decoder: latches a one-hot read or write select for
// HOLD_CYCLES minor cycles, with sticky rail and direction error flags.
module tank_decoder_seq #(
  parameter int ADDR_BITS   = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  tank_decoder_seq_if.slave bus
);
  localparam int TANKS = 2 ** ADDR_BITS;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TANKS-1:0] sel_in_q, sel_in_d;
  logic [TANKS-1:0] sel_out_q, sel_out_d;
  logic             busy_q, busy_d;
  logic             rail_err_q, rail_err_d;
  logic             dir_err_q, dir_err_d;

  logic             req;
  logic             rail_ok;
  logic             dir_ok;
  logic             valid_req;
  logic             sample_open;
  logic [TANKS-1:0] addr_onehot;

  assign req       = bus.t_in | bus.t_out;
  assign rail_ok   = &(bus.f_pos ^ bus.f_neg);
  assign dir_ok    = ~(bus.t_in & bus.t_out);
  assign valid_req = req & rail_ok & dir_ok;

  // Requests are only looked at from IDLE or on the strobe that ends a hold.
  assign sample_open = bus.minor_strobe &
                       ((state_q == IDLE) | (cnt_q == 4'd1));

  always_comb begin
    addr_onehot            = '0;
    addr_onehot[bus.f_pos] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_in_d   = sel_in_q;
    sel_out_d  = sel_out_q;
    busy_d     = busy_q;
    rail_err_d = rail_err_q & ~bus.err_clr;
    dir_err_d  = dir_err_q & ~bus.err_clr;

    if (sample_open) begin
      if (valid_req) begin
        state_d   = ACTIVE;
        cnt_d     = 4'(HOLD_CYCLES);
        sel_in_d  = bus.t_in  ? addr_onehot : '0;
        sel_out_d = bus.t_out ? addr_onehot : '0;
        busy_d    = 1'b1;
      end else begin
        state_d   = IDLE;
        cnt_d     = '0;
        sel_in_d  = '0;
        sel_out_d = '0;
        busy_d    = 1'b0;
        // Error sets are applied after the clear so a same-clock set wins.
        if (req && !rail_ok) begin
          rail_err_d = 1'b1;
        end
        if (bus.t_in && bus.t_out) begin
          dir_err_d = 1'b1;
        end
      end
    end else if (bus.minor_strobe && (state_q == ACTIVE)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_in_q   <= '0;
      sel_out_q  <= '0;
      busy_q     <= 1'b0;
      rail_err_q <= 1'b0;
      dir_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_in_q   <= sel_in_d;
      sel_out_q  <= sel_out_d;
      busy_q     <= busy_d;
      rail_err_q <= rail_err_d;
      dir_err_q  <= dir_err_d;
    end
  end

  assign bus.t_sel_in  = sel_in_q;
  assign bus.t_sel_out = sel_out_q;
  assign bus.busy      = busy_q;
  assign bus.rail_err  = rail_err_q;
  assign bus.dir_err   = dir_err_q;
endmodule

// File: tb/tb_tank_decoder_seq.sv
// Directed bench for tank_decoder_seq across three configurations:
// (2 bits, hold 1), (2 bits, hold 3) and (3 bits, hold 2).
module tb_tank_decoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tank_decoder_seq_if #(.ADDR_BITS(2)) bus_a ();
  tank_decoder_seq_if #(.ADDR_BITS(2)) bus_b ();
  tank_decoder_seq_if #(.ADDR_BITS(3)) bus_c ();

  tank_decoder_seq #(.ADDR_BITS(2), .HOLD_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  tank_decoder_seq #(.ADDR_BITS(2), .HOLD_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  tank_decoder_seq #(.ADDR_BITS(3), .HOLD_CYCLES(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Each strobe task drives one sampling clock and returns 1 ns after the edge.
  task automatic strobe_a(input logic [1:0] fp, input logic [1:0] fn,
                          input logic ti, input logic to, input logic clr);
    @(negedge clk);
    bus_a.minor_strobe = 1'b1; bus_a.f_pos = fp; bus_a.f_neg = fn;
    bus_a.t_in = ti; bus_a.t_out = to; bus_a.err_clr = clr;
    @(posedge clk); #1;
    bus_a.minor_strobe = 1'b0; bus_a.f_pos = '0; bus_a.f_neg = '0;
    bus_a.t_in = 1'b0; bus_a.t_out = 1'b0; bus_a.err_clr = 1'b0;
  endtask

  task automatic strobe_b(input logic [1:0] fp, input logic [1:0] fn,
                          input logic ti, input logic to);
    @(negedge clk);
    bus_b.minor_strobe = 1'b1; bus_b.f_pos = fp; bus_b.f_neg = fn;
    bus_b.t_in = ti; bus_b.t_out = to;
    @(posedge clk); #1;
    bus_b.minor_strobe = 1'b0; bus_b.f_pos = '0; bus_b.f_neg = '0;
    bus_b.t_in = 1'b0; bus_b.t_out = 1'b0;
  endtask

  task automatic strobe_c(input logic [2:0] fp, input logic [2:0] fn,
                          input logic ti, input logic to);
    @(negedge clk);
    bus_c.minor_strobe = 1'b1; bus_c.f_pos = fp; bus_c.f_neg = fn;
    bus_c.t_in = ti; bus_c.t_out = to;
    @(posedge clk); #1;
    bus_c.minor_strobe = 1'b0; bus_c.f_pos = '0; bus_c.f_neg = '0;
    bus_c.t_in = 1'b0; bus_c.t_out = 1'b0;
  endtask

  task automatic clr_pulse_a();
    @(negedge clk);
    bus_a.err_clr = 1'b1;
    @(posedge clk); #1;
    bus_a.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus_a.t_sel_in, bus_a.t_sel_out, bus_a.busy, bus_a.rail_err, bus_a.dir_err} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: got %b/%b/%b/%b/%b want all zero", bus_a.t_sel_in,
               bus_a.t_sel_out, bus_a.busy, bus_a.rail_err, bus_a.dir_err);
    end
    checks++;
    if ({bus_b.t_sel_in, bus_b.t_sel_out, bus_b.busy} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %b/%b/%b want all zero", bus_b.t_sel_in, bus_b.t_sel_out, bus_b.busy);
    end
    checks++;
    if ({bus_c.t_sel_in, bus_c.t_sel_out, bus_c.busy} !== 17'b0) begin
      errors++;
      $display("[TB] FAIL reset_c: got %b/%b/%b want all zero", bus_c.t_sel_in, bus_c.t_sel_out, bus_c.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    strobe_a(2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus_a.t_sel_in !== 4'b0100 || bus_a.t_sel_out !== 4'b0000 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_accept: got in=%b out=%b busy=%b want in=0100 out=0000 busy=1",
               bus_a.t_sel_in, bus_a.t_sel_out, bus_a.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.t_sel_in !== 4'b0100 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_hold_no_strobe: got in=%b busy=%b want in=0100 busy=1",
               bus_a.t_sel_in, bus_a.busy);
    end
    strobe_a(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus_a.t_sel_in !== 4'b0000 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release: got in=%b busy=%b want in=0000 busy=0",
               bus_a.t_sel_in, bus_a.busy);
    end
  endtask

  task automatic test_hold3();
    strobe_b(2'b11, 2'b00, 1'b0, 1'b1);
    checks++;
    if (bus_b.t_sel_out !== 4'b1000 || bus_b.t_sel_in !== 4'b0000 || bus_b.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold3_accept: got out=%b in=%b busy=%b want out=1000 in=0000 busy=1",
               bus_b.t_sel_out, bus_b.t_sel_in, bus_b.busy);
    end
    strobe_b(2'b11, 2'b01, 1'b0, 1'b1);
    checks++;
    if (bus_b.t_sel_out !== 4'b1000 || bus_b.rail_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold3_strobe1: got out=%b rail_err=%b want out=1000 rail_err=0",
               bus_b.t_sel_out, bus_b.rail_err);
    end
    strobe_b(2'b01, 2'b10, 1'b1, 1'b0);
    checks++;
    if (bus_b.t_sel_out !== 4'b1000 || bus_b.t_sel_in !== 4'b0000 || bus_b.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold3_strobe2_ignored: got out=%b in=%b busy=%b want out=1000 in=0000 busy=1",
               bus_b.t_sel_out, bus_b.t_sel_in, bus_b.busy);
    end
    strobe_b(2'b00, 2'b00, 1'b0, 1'b0);
    checks++;
    if ({bus_b.t_sel_in, bus_b.t_sel_out, bus_b.busy, bus_b.rail_err, bus_b.dir_err} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL hold3_release: got in=%b out=%b busy=%b rail=%b dir=%b want all zero",
               bus_b.t_sel_in, bus_b.t_sel_out, bus_b.busy, bus_b.rail_err, bus_b.dir_err);
    end
  endtask

  task automatic test_rail_error();
    strobe_a(2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus_a.rail_err !== 1'b1 || bus_a.t_sel_out !== 4'b0000 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rail_set: got rail=%b out=%b busy=%b want rail=1 out=0000 busy=0",
               bus_a.rail_err, bus_a.t_sel_out, bus_a.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rail_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rail_sticky: got %b want 1", bus_a.rail_err);
    end
    clr_pulse_a();
    checks++;
    if (bus_a.rail_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rail_clear: got %b want 0", bus_a.rail_err);
    end
    strobe_a(2'b11, 2'b01, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus_a.rail_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rail_set_beats_clear: got %b want 1", bus_a.rail_err);
    end
    clr_pulse_a();
  endtask

  task automatic test_dir_error();
    strobe_a(2'b01, 2'b10, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus_a.dir_err !== 1'b1 || bus_a.rail_err !== 1'b0 || bus_a.busy !== 1'b0 ||
        bus_a.t_sel_in !== 4'b0000 || bus_a.t_sel_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL dir_set: got dir=%b rail=%b busy=%b in=%b out=%b want dir=1 rail=0 busy=0 sel=0",
               bus_a.dir_err, bus_a.rail_err, bus_a.busy, bus_a.t_sel_in, bus_a.t_sel_out);
    end
    strobe_a(2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus_a.t_sel_out !== 4'b0010 || bus_a.busy !== 1'b1 || bus_a.dir_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dir_then_valid: got out=%b busy=%b dir=%b want out=0010 busy=1 dir=1",
               bus_a.t_sel_out, bus_a.busy, bus_a.dir_err);
    end
    strobe_a(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    clr_pulse_a();
    checks++;
    if (bus_a.dir_err !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dir_clear: got dir=%b busy=%b want dir=0 busy=0", bus_a.dir_err, bus_a.busy);
    end
  endtask

  task automatic test_back_to_back();
    strobe_a(2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus_a.t_sel_in !== 4'b0001 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got in=%b busy=%b want in=0001 busy=1", bus_a.t_sel_in, bus_a.busy);
    end
    strobe_a(2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus_a.t_sel_in !== 4'b0000 || bus_a.t_sel_out !== 4'b0010 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_second: got in=%b out=%b busy=%b want in=0000 out=0010 busy=1",
               bus_a.t_sel_in, bus_a.t_sel_out, bus_a.busy);
    end
    strobe_a(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus_a.t_sel_in !== 4'b0000 || bus_a.t_sel_out !== 4'b0000 || bus_a.busy !== 1'b0 ||
        bus_a.rail_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_invalid_on_end: got in=%b out=%b busy=%b rail=%b want sel=0 busy=0 rail=1",
               bus_a.t_sel_in, bus_a.t_sel_out, bus_a.busy, bus_a.rail_err);
    end
    clr_pulse_a();
  endtask

  task automatic test_reset_active();
    strobe_c(3'b101, 3'b010, 1'b1, 1'b0);
    checks++;
    if (bus_c.t_sel_in !== 8'b0010_0000 || bus_c.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst8_accept: got in=%b busy=%b want in=00100000 busy=1", bus_c.t_sel_in, bus_c.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus_c.t_sel_in !== 8'b0 || bus_c.t_sel_out !== 8'b0 || bus_c.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst8_async_drop: got in=%b out=%b busy=%b want all zero",
               bus_c.t_sel_in, bus_c.t_sel_out, bus_c.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    strobe_c(3'b011, 3'b100, 1'b0, 1'b1);
    checks++;
    if (bus_c.t_sel_out !== 8'b0000_1000 || bus_c.t_sel_in !== 8'b0 || bus_c.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst8_after: got out=%b in=%b busy=%b want out=00001000 in=0 busy=1",
               bus_c.t_sel_out, bus_c.t_sel_in, bus_c.busy);
    end
    strobe_c(3'b000, 3'b000, 1'b0, 1'b0);
    checks++;
    if (bus_c.t_sel_out !== 8'b0000_1000) begin
      errors++;
      $display("[TB] FAIL rst8_hold: got out=%b want 00001000", bus_c.t_sel_out);
    end
    strobe_c(3'b000, 3'b000, 1'b0, 1'b0);
    checks++;
    if (bus_c.t_sel_out !== 8'b0 || bus_c.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst8_release: got out=%b busy=%b want out=0 busy=0", bus_c.t_sel_out, bus_c.busy);
    end
  endtask

  initial begin
    bus_a.minor_strobe = 1'b0; bus_a.f_pos = '0; bus_a.f_neg = '0;
    bus_a.t_in = 1'b0; bus_a.t_out = 1'b0; bus_a.err_clr = 1'b0;
    bus_b.minor_strobe = 1'b0; bus_b.f_pos = '0; bus_b.f_neg = '0;
    bus_b.t_in = 1'b0; bus_b.t_out = 1'b0; bus_b.err_clr = 1'b0;
    bus_c.minor_strobe = 1'b0; bus_c.f_pos = '0; bus_c.f_neg = '0;
    bus_c.t_in = 1'b0; bus_c.t_out = 1'b0; bus_c.err_clr = 1'b0;

    test_reset();
    test_basic_write();
    test_hold3();
    test_rail_error();
    test_dir_error();
    test_back_to_back();
    test_reset_active();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tank_decoder_seq.md
TANK_DECODER_SEQ -- requirements
Module: tank_decoder_seq

Interface
REQ-001 Parameter ADDR_BITS, default 2, number of dual-rail tank-address bits; the block SHALL support 1..4.
REQ-002 Parameter HOLD_CYCLES, default 1, number of minor cycles a selection is held; the block SHALL support 1..15.
REQ-003 Derived constant TANKS = 2**ADDR_BITS, the one-hot output width.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 minor_strobe  input  1  one-clock pulse marking each minor-cycle boundary.
REQ-007 f_pos  input  ADDR_BITS  positive rail of the address bits (bit i = address bit i).
REQ-008 f_neg  input  ADDR_BITS  negative rail of the address bits.
REQ-009 t_in  input  1  request to write into the selected tank.
REQ-010 t_out  input  1  request to read from the selected tank.
REQ-011 err_clr  input  1  clears the sticky error flags.
REQ-012 t_sel_in  output  TANKS  one-hot tank write-select.
REQ-013 t_sel_out  output  TANKS  one-hot tank read-select.
REQ-014 busy  output  1  high while a selection is held.
REQ-015 rail_err  output  1  sticky flag for a dual-rail violation.
REQ-016 dir_err  output  1  sticky flag for t_in and t_out asserted together.

Function
REQ-017 Sampling: the block SHALL sample inputs only in a clock where minor_strobe=1; in all other clocks, inputs SHALL be ignored.
REQ-018 Request: a request exists in a sampling clock when (t_in|t_out)=1.
REQ-019 Rail validity: a request SHALL be valid only if f_pos[i]^f_neg[i]=1 for every bit i and t_in&t_out=0.
REQ-020 Address: the decoded address SHALL be taken from f_pos.
REQ-021 FSM states: the block SHALL have exactly two states, IDLE and ACTIVE.
REQ-022 IDLE transition: in IDLE, a valid request SHALL latch the address and direction, load the hold counter with HOLD_CYCLES, and move the FSM to ACTIVE at the next clock edge.
REQ-023 Output latency: outputs SHALL be registered; the select becomes visible exactly one clock after the sampling strobe.
REQ-024 ACTIVE outputs: in ACTIVE, exactly one bit of t_sel_in (write) or of t_sel_out (read) SHALL be 1, at the index of the latched address; the other vector SHALL be all zero; busy SHALL be 1.
REQ-025 Hold count: in ACTIVE, each minor_strobe SHALL decrement the hold counter.
REQ-026 Hold release: the strobe that decrements the counter from 1 to 0 SHALL end the hold; at the next edge, all selects and busy SHALL be 0 and the FSM SHALL enter IDLE.
REQ-027 Back-to-back: a valid request present on the hold-ending strobe SHALL be accepted directly; the FSM SHALL stay in ACTIVE with the new address, direction and a reloaded counter, and selects SHALL change with no zero gap.
REQ-028 Ignored requests: requests on non-ending strobes in ACTIVE SHALL be ignored and SHALL NOT raise errors.
REQ-029 Invalid requests: a sampled invalid request (in IDLE, or on a hold-ending strobe) SHALL select nothing; rail_err and/or dir_err SHALL be set as applicable; the FSM SHALL end in IDLE.
REQ-030 Error clear: error flags SHALL stay set until err_clr=1; if an error is set and cleared in the same clock, the set SHALL win.
REQ-031 All-zero outputs: t_sel_in and t_sel_out SHALL never have more than one bit set in total, and SHALL be all zero in IDLE.

Reset
REQ-032 While rst=1: FSM=IDLE, hold counter=0, t_sel_in=0, t_sel_out=0, busy=0, rail_err=0, dir_err=0, all asynchronously.
REQ-033 Reset asserted in ACTIVE SHALL drop all selects immediately, without waiting for a clock edge.
REQ-034 After rst deasserts, the first strobe SHALL be treated as an IDLE sample.

Verification
REQ-035 Defaults, HOLD_CYCLES=1: strobe with f_pos=2'b10, f_neg=2'b01, t_in=1 -> next clock t_sel_in=4'b0100, busy=1; next strobe -> t_sel_in=0, busy=0.
REQ-036 HOLD_CYCLES=3, read of address 3 -> t_sel_out=4'b1000 for exactly 3 strobes; a request on strobe 2 is ignored; no error flags raised.
REQ-037 f_pos=2'b11, f_neg=2'b01, t_out=1 -> rail_err=1, no select; err_clr pulse -> rail_err=0; err_clr concurrent with a new violation -> rail_err stays 1.
REQ-038 t_in=t_out=1 with a valid address -> dir_err=1, busy=0; a subsequent valid request is still accepted.
REQ-039 Back-to-back: write to address 0, then a read of address 1 on the hold-ending strobe -> t_sel_in=0001 is followed directly by t_sel_out=0010, busy stays 1 throughout.
REQ-040 rst pulsed mid-ACTIVE with ADDR_BITS=3 -> all 8-bit selects 0 asynchronously; the next valid request behaves as from IDLE.
